fisr_axil_ctrl_mc: RTL
======================

// Module: fisr_axil_ctrl_mc
// PURPOSE
//  AXI4-Lite slave controller for a multi-channel fast-inverse-square-root engine; next generation of fisr_controller_v2.
//  Holds NUM_CH input operands (X) and results (Y) in a memory-mapped register file.
//  On START it streams every X to an external pipelined FISR core over valid/ready and collects results tagged by channel.
//  Raises DONE/irq when all results have returned. Sits between the PS AXI interconnect and the FISR datapath.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 supported.
//  C_S_AXI_ADDR_WIDTH  7   AXI address width; must cover 0x10+8*NUM_CH.
//  NUM_CH              4   channel count, 1..8; CH_W = max(1,clog2(NUM_CH)).
// PORTS
//  s00_axi_aclk     in   1   the block's single clock.
//  s00_axi_aresetn  in   1   reset: synchronous, active-low.
//  s00_axi_aw*/w*/b*/ar*/r*  std AXI4-Lite slave (awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready).
//  core_in_data     out  32   operand X to the FISR core.
//  core_in_ch       out  CH_W channel tag of the operand.
//  core_in_valid    out  1    operand valid.
//  core_in_ready    in   1    core accepts operand.
//  core_out_data    in   32   result Y.
//  core_out_ch      in   CH_W channel tag of the result.
//  core_out_valid   in   1    result valid; no backpressure, always consumed.
//  irq              out  1    DONE & IRQ_EN, registered.
// BEHAVIOUR
//  Reset: all outputs 0 (awready/wready/arready/bvalid/rvalid/core_in_valid/irq); X, Y, CTRL, STATUS = 0; FSM IDLE.
//  Reg map: 0x00 CTRL (b0 START write-1 self-clearing, reads 0; b1 IRQ_EN); 0x04 STATUS (b0 BUSY RO, b1 DONE W1C);
//    0x08 rsvd (reads 0); 0x10+8*ch X[ch] RW; 0x14+8*ch Y[ch] RO. Writes to RO/reserved: ignored, OKAY.
//  Address >= 0x10+8*NUM_CH: write ignored, read returns 0, resp SLVERR (2'b10).
//  Write: awready and wready pulse together for 1 cycle when awvalid & wvalid & !bvalid; reg updated that edge
//    per wstrb byte lanes; bvalid next cycle, held until bready.
//  Read: arready pulses 1 cycle when arvalid & !rvalid; rdata/rvalid registered next cycle, held until rready.
//    Read and write may complete in the same cycle.
//  FSM IDLE -> ISSUE on START write (clears DONE). START while BUSY ignored.
//  ISSUE: core_in_valid=1, core_in_data=X[idx], core_in_ch=idx; on valid&ready idx++; after idx=NUM_CH-1 accepted -> WAIT.
//    X sampled at handshake, so X writes during ISSUE affect only not-yet-issued channels.
//  ISSUE/WAIT: each core_out_valid writes Y[core_out_ch] and rx_cnt++; results may arrive during ISSUE, any order.
//  WAIT -> IDLE when rx_cnt reaches NUM_CH (incl. same-cycle last result); DONE set that edge, irq 1 cycle later if IRQ_EN.
//  BUSY = (state != IDLE). core_out_valid in IDLE ignored (Y unchanged).
//  Same-cycle DONE W1C and DONE set: set wins. Same-cycle START write and completion: START ignored (still BUSY).
//  Reset mid-operation: FSM IDLE, idx/rx_cnt 0, core_in_valid low next edge; results arriving after are ignored.
//  rx_cnt width CH_W+1; no wrap.
// TESTING
//  Core model: latency 3, returns 0x5F3759DF-(X>>1), core_in_ready random 50%.
//  T1 X0=0x40800000, NUM_CH=4 all X0, START -> BUSY=1; after all results Y[0..3]=0x3EF759DF, STATUS=0x2, irq=0 (IRQ_EN=0).
//  T2 CTRL=0x2 then START with X[ch]=0x3F800000+ch<<20 -> irq=1 after last result; write STATUS=0x2 -> DONE=0, irq=0.
//  T3 START again while BUSY -> ignored: exactly NUM_CH core_in handshakes, one DONE.
//  T4 read 0x40 / write 0x44 (NUM_CH=4) -> rresp=bresp=SLVERR, rdata=0; write Y[1] -> unchanged, OKAY.
//  T5 wstrb=4'b0011 writing 0xAABBCCDD over X2=0x11223344 -> X2 reads 0x1122CCDD.
//  T6 aresetn low 1 cycle mid-ISSUE -> core_in_valid=0 next edge, STATUS=0, all X/Y=0; late core results don't touch Y.

Source files
------------

// File: rtl/fisr_axil_ctrl_mc.sv
// fisr_axil_ctrl_mc
//   AXI4-Lite slave front end for a multi-channel fast-inverse-square-root
//   engine. It holds NUM_CH operands (X) and NUM_CH results (Y) in a register
//   file. On START it streams every X to an external pipelined core and
//   collects the tagged results. When all results are back it raises DONE and,
//   if enabled, irq.
//
//   Register map (byte addresses):
//     0x00 CTRL    b0 START (write 1, self-clearing, reads 0), b1 IRQ_EN
//     0x04 STATUS  b0 BUSY (RO), b1 DONE (write 1 to clear)
//     0x08/0x0C    reserved, read 0
//     0x10+8*ch    X[ch] RW
//     0x14+8*ch    Y[ch] RO
//   Any address at or above the channel window returns SLVERR.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn  clock, synchronous active-low reset
//   s00_axi_*                       AXI4-Lite slave
//   core_in_*                       operand stream to the core (valid/ready)
//   core_out_*                      result stream from the core (no backpressure)
//   irq                             registered DONE & IRQ_EN

// Per-channel operand/result storage.
//   x_we/x_strb/x_wdata : bus write into X, one enable per byte lane
//   y_we/y_wdata        : result capture into Y
//   x_q/y_q             : current register contents
module fisr_ch_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_we,
  input  logic [3:0]  x_strb,
  input  logic [31:0] x_wdata,
  input  logic        y_we,
  input  logic [31:0] y_wdata,
  output logic [31:0] x_q,
  output logic [31:0] y_q
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (x_we) begin
        for (int b = 0; b < 4; b++)
          if (x_strb[b]) x_q[8*b +: 8] <= x_wdata[8*b +: 8];
      end
      if (y_we) y_q <= y_wdata;
    end
  end
endmodule

module fisr_axil_ctrl_mc #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int NUM_CH             = 4,
  localparam int CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [31:0]                     core_in_data,
  output logic [CH_W-1:0]                 core_in_ch,
  output logic                            core_in_valid,
  input  logic                            core_in_ready,
  input  logic [31:0]                     core_out_data,
  input  logic [CH_W-1:0]                 core_out_ch,
  input  logic                            core_out_valid,
  output logic                            irq
);
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int AWW  = AW - 2;            // word-address width
  localparam int AW1  = AW + 1;
  localparam int CHW1 = CH_W + 1;
  localparam logic [AW:0]     TOP_ADDR = AW1'(16 + 8*NUM_CH);
  localparam logic [AWW-1:0]  CTRL_W   = AWW'(0);
  localparam logic [AWW-1:0]  STAT_W   = AWW'(1);
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   RX_FULL  = CHW1'(NUM_CH);
  localparam logic [1:0]      OKAY     = 2'b00;
  localparam logic [1:0]      SLVERR   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  typedef struct packed {
    logic           en;
    logic           ok;      // address inside the decoded window
    logic [AWW-1:0] word;
    logic [3:0]     strb;
    logic [31:0]    data;
  } wr_req_t;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic [31:0]     data;
  } core_res_t;

  wire clk   = s00_axi_aclk;
  wire rst_n = s00_axi_aresetn;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic [CH_W:0]       rx_q, rx_d;
  logic                done_set;
  logic                irq_en_q, done_q;
  logic [NUM_CH-1:0][31:0] x_q, y_q, rd_ch;
  logic [NUM_CH-1:0]   x_we, y_we;
  logic [31:0]         rd_mux;
  logic                rd_ok;
  logic [AWW-1:0]      rd_word;

  wr_req_t   wr;
  core_res_t res;

  // ---------------- write channel ----------------
  // AW and W are taken together in one cycle; no new write until B drains.
  assign s00_axi_awready = rst_n & s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
  assign s00_axi_wready  = s00_axi_awready;

  assign wr = '{en:   s00_axi_awready,
                ok:   ({1'b0, s00_axi_awaddr} < TOP_ADDR),
                word: s00_axi_awaddr[AW-1:2],
                strb: s00_axi_wstrb,
                data: s00_axi_wdata};

  wire ctrl_wr    = wr.en & wr.ok & (wr.word == CTRL_W) & wr.strb[0];
  wire status_w1c = wr.en & wr.ok & (wr.word == STAT_W) & wr.strb[0] & wr.data[1];
  wire start_go   = ctrl_wr & wr.data[0] & (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= OKAY;
      irq_en_q       <= 1'b0;
      done_q         <= 1'b0;
      irq            <= 1'b0;
    end else begin
      if (wr.en) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= wr.ok ? OKAY : SLVERR;
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
      if (ctrl_wr) irq_en_q <= wr.data[1];
      // completion beats a same-cycle W1C
      if (done_set)                   done_q <= 1'b1;
      else if (start_go | status_w1c) done_q <= 1'b0;
      irq <= done_q & irq_en_q;
    end
  end

  // ---------------- read channel ----------------
  assign s00_axi_arready = rst_n & s00_axi_arvalid & ~s00_axi_rvalid;
  assign rd_word = s00_axi_araddr[AW-1:2];
  assign rd_ok   = ({1'b0, s00_axi_araddr} < TOP_ADDR);

  always_comb begin
    rd_mux = '0;
    if (rd_ok) begin
      if (rd_word == CTRL_W)      rd_mux = {30'b0, irq_en_q, 1'b0};
      else if (rd_word == STAT_W) rd_mux = {30'b0, done_q, (state_q != S_IDLE)};
      for (int c = 0; c < NUM_CH; c++) rd_mux = rd_mux | rd_ch[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= OKAY;
    end else if (s00_axi_arready) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= rd_mux;
      s00_axi_rresp  <= rd_ok ? OKAY : SLVERR;
    end else if (s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- channel register file ----------------
  // Results are only accepted while an operation is in flight.
  assign res = '{vld: core_out_valid & (state_q != S_IDLE),
                 ch: core_out_ch, data: core_out_data};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [AWW-1:0]  XW  = AWW'(4 + 2*c);
    localparam logic [AWW-1:0]  YW  = AWW'(5 + 2*c);
    localparam logic [CH_W-1:0] CHI = CH_W'(c);

    assign x_we[c]  = wr.en & wr.ok & (wr.word == XW);
    assign y_we[c]  = res.vld & (res.ch == CHI);
    assign rd_ch[c] = (rd_word == XW) ? x_q[c] :
                      (rd_word == YW) ? y_q[c] : 32'h0;

    fisr_ch_regs u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .x_we    (x_we[c]),
      .x_strb  (wr.strb),
      .x_wdata (wr.data),
      .y_we    (y_we[c]),
      .y_wdata (res.data),
      .x_q     (x_q[c]),
      .y_q     (y_q[c])
    );
  end

  // ---------------- issue/collect FSM ----------------
  // X is muxed live, so a write to a not-yet-issued channel is picked up.
  assign core_in_valid = (state_q == S_ISSUE);
  assign core_in_ch    = idx_q;
  assign core_in_data  = x_q[idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rx_d     = rx_q;
    done_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          rx_d    = '0;
        end
      end
      S_ISSUE: begin
        if (res.vld) rx_d = rx_q + CHW1'(1);
        if (core_in_ready) begin
          if (idx_q == LAST_IDX) state_d = S_WAIT;
          else                   idx_d   = idx_q + CH_W'(1);
        end
      end
      S_WAIT: begin
        if (res.vld) rx_d = rx_q + CHW1'(1);
        // a last result arriving this cycle completes immediately
        if (rx_d == RX_FULL) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
endmodule
